quant_wb_ctrl: RTL and testbench
================================

# quant_wb_ctrl

Write-back sequencer for quantized results. It waits on the registered quant-done flag, then reads N_WORDS entries from the quantized-result buffer (1-cycle read latency) and writes each one to memory over a valid/ready port. When the last word is accepted, it pulses `wb_clear` for exactly one cycle to drop the quant-done flag. It sits between the quantizer's result buffer and the memory write port, and consumes the flag owned by the surrounding DP_CTRL logic.

## Interface
- `DATA_W`, 8: quantized word width.
- `ADDR_W`, 10: memory address width.
- `N_WORDS`, 16: words per write-back. Must be ≥1; elaboration error otherwise.
- `BASE_ADDR`, 0: first memory address.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `quant_done_flag`  in  1  sticky quant-done flag; high means results are ready.
- `buf_rd_en`  out  1  result-buffer read strobe.
- `buf_rd_addr`  out  $clog2(N_WORDS) (min 1)  result-buffer index.
- `buf_rd_data`  in  DATA_W  buffer data, valid the cycle after `buf_rd_en`.
- `mem_wr_valid`  out  1  write request.
- `mem_wr_ready`  in  1  memory accepts the write.
- `mem_wr_addr`  out  ADDR_W  write address.
- `mem_wr_data`  out  DATA_W  write data.
- `wb_clear`  out  1  one-cycle pulse that clears the quant-done flag.
- `wb_busy`  out  1  high in any state other than IDLE.

## Operation
- FSM has five states: IDLE, RD, LAT, WR, DONE.
- **IDLE**
  - `quant_done_flag` = 1 → RD, with idx = 0.
  - Otherwise stay in IDLE.
- **RD**: `buf_rd_en` = 1 and `buf_rd_addr` = idx for one cycle → LAT.
- **LAT**: `buf_rd_data` is captured into the hold register at the end of this cycle → WR.
- **WR**
  - `mem_wr_valid` = 1, `mem_wr_addr` = BASE_ADDR + idx (truncated to ADDR_W), `mem_wr_data` = hold register.
  - `mem_wr_ready` = 1 with idx == N_WORDS-1 → DONE.
  - `mem_wr_ready` = 1 otherwise → idx+1, then RD.
  - `mem_wr_ready` = 0 → stay in WR.
- **DONE**: `wb_clear` = 1 → IDLE.
- The flag is low by the next cycle, so IDLE does not re-trigger.
- Handshake: while `mem_wr_valid` = 1 and `mem_wr_ready` = 0, the valid, addr and data outputs hold steady. Valid never drops without a transfer.
- `quant_done_flag` falling during a write-back is ignored; the sequence completes.
- A new done event during a write-back is lost, because clear has priority in the flag. Upstream must not signal done while `wb_busy` = 1.
- Address wrap: BASE_ADDR + idx wraps modulo 2^ADDR_W with no error.
- Reset, including mid-transfer:
  - State → IDLE.
  - idx, hold register and all outputs → 0.
  - Memory discards any incomplete block.

## Timing
- Reset values: `buf_rd_en`, `buf_rd_addr`, `mem_wr_valid`, `mem_wr_addr`, `mem_wr_data`, `wb_clear` and `wb_busy` are all 0.
- All outputs decode from state, idx and the hold register. No combinational path from `mem_wr_ready` to outputs.
- With IDLE sampling the flag high at cycle t and `mem_wr_ready` tied to 1:
  - RD at t+1, LAT at t+2, first WR at t+3.
  - Word k is written at t+3+3k.
  - `wb_clear` is high at t+3·N_WORDS+1.
  - `wb_busy` is high from t+1 through t+3·N_WORDS+1 inclusive.
- Each cycle of `mem_wr_ready` = 0 in WR adds one cycle.
- Throughput: one word per 3 cycles. A faster (pipelined) version is out of scope.

## Structure
- Shared package `smac_wb_pkg`:
  - `wb_state_t` enum (IDLE, RD, LAT, WR, DONE).
  - The function computing the index width as $clog2 with a minimum of 1.
- Single module, no sub-module. The quant-done flag register stays an instance in the DP_CTRL parent, with `wb_clear` wired to its clear input.

## Test plan
- Reset, then flag held low for 20 cycles → no `buf_rd_en`, `mem_wr_valid` or `wb_clear`; `wb_busy` = 0.
- N_WORDS=4, BASE_ADDR=0x10, buffer {0x11,0x22,0x33,0x44}, ready = 1, flag seen at t → writes (0x10,0x11), (0x11,0x22), (0x12,0x33), (0x13,0x44) at t+3, t+6, t+9, t+12. `wb_clear` is a single pulse at t+13. No retrigger afterwards.
- Ready low for 5 cycles on word 2 → valid, addr 0x12 and data 0x33 held stable for 5 cycles. `wb_clear` moves to t+18.
- BASE_ADDR=0x3FE, ADDR_W=10, N_WORDS=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- `rst_n` asserted during WR of word 1 → all outputs 0 asynchronously. After release with the flag high, the sequence restarts at idx 0.
- N_WORDS=1 → one write at t+3 and `wb_clear` at t+4. Flag toggling low mid-sequence does not abort.

Source files
------------

// File: rtl/smac_wb_pkg.sv
// Shared definitions for the quantized-result write-back sequencer.
//   wb_state_t : write-back FSM states (IDLE, RD, LAT, WR, DONE)
//   idx_width  : width of a buffer index for n entries ($clog2, minimum 1)
package smac_wb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } wb_state_t;

  // A single-entry buffer still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/quant_wb_ctrl.sv
// Write-back sequencer for quantized results.
// Waits for the sticky quant-done flag, then for each of N_WORDS entries reads
// the result buffer (1-cycle latency), holds the word and writes it to memory
// over a valid/ready port. After the last accepted write it pulses wb_clear for
// one cycle so the parent can drop the quant-done flag.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   quant_done_flag   results ready (sticky flag owned by the parent)
//   buf_rd_en/addr    result-buffer read strobe and index
//   buf_rd_data       buffer data, valid the cycle after buf_rd_en
//   mem_wr_valid/ready/addr/data  memory write request port
//   wb_clear          one-cycle pulse clearing the quant-done flag
//   wb_busy           high whenever the sequencer is not idle
module quant_wb_ctrl
  import smac_wb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int N_WORDS   = 16,
  parameter int BASE_ADDR = 0,
  localparam int IDX_W    = idx_width(N_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              quant_done_flag,
  output logic              buf_rd_en,
  output logic [IDX_W-1:0]  buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              wb_clear,
  output logic              wb_busy
);

  if (N_WORDS < 1) begin : g_bad_n_words
    $error("quant_wb_ctrl: N_WORDS must be >= 1");
  end

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  wb_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              buf_rd_en_q, buf_rd_en_d;
  logic [IDX_W-1:0]  buf_rd_addr_q, buf_rd_addr_d;
  logic              mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              wb_clear_q, wb_clear_d;
  logic              wb_busy_q, wb_busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (quant_done_flag) begin
          state_d = RD;
          idx_d   = '0;
        end
      end
      RD:   state_d = LAT;
      LAT: begin
        hold_d  = buf_rd_data;
        state_d = WR;
      end
      WR: begin
        if (mem_wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so that, once registered, they
    // line up with the state they belong to. A stalled WR keeps state, idx and
    // hold unchanged, so valid/addr/data stay steady without extra logic.
    buf_rd_en_d    = (state_d == RD);
    buf_rd_addr_d  = (state_d == RD) ? idx_d : '0;
    mem_wr_valid_d = (state_d == WR);
    mem_wr_addr_d  = (state_d == WR) ? (BASE + ADDR_W'(idx_d)) : '0;
    mem_wr_data_d  = (state_d == WR) ? hold_d : '0;
    wb_clear_d     = (state_d == DONE);
    wb_busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      hold_q         <= '0;
      buf_rd_en_q    <= 1'b0;
      buf_rd_addr_q  <= '0;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      wb_clear_q     <= 1'b0;
      wb_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      hold_q         <= hold_d;
      buf_rd_en_q    <= buf_rd_en_d;
      buf_rd_addr_q  <= buf_rd_addr_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      wb_clear_q     <= wb_clear_d;
      wb_busy_q      <= wb_busy_d;
    end
  end

  assign buf_rd_en    = buf_rd_en_q;
  assign buf_rd_addr  = buf_rd_addr_q;
  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign wb_clear     = wb_clear_q;
  assign wb_busy      = wb_busy_q;

endmodule

// File: tb/tb_quant_wb_ctrl.sv
// Bench for quant_wb_ctrl: a 4-word instance with a wrapping base address is
// followed by a scoreboard monitor; a 1-word instance gets a directed check.
module tb_quant_wb_ctrl;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 10;
  localparam int N_WORDS   = 4;
  localparam int BASE_ADDR = 'h3FE;
  localparam int IDX_W     = smac_wb_pkg::idx_width(N_WORDS);
  localparam int B_IDX_W   = smac_wb_pkg::idx_width(1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic              flag = 1'b0;
  logic              flag_set = 1'b0;
  logic              flag_drop = 1'b0;
  logic              buf_rd_en;
  logic [IDX_W-1:0]  buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data = '0;
  logic              mem_wr_valid;
  logic              mem_wr_ready = 1'b1;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              wb_clear;
  logic              wb_busy;
  logic [DATA_W-1:0] buf_mem [N_WORDS];

  // Single-word instance signals
  logic                b_flag = 1'b0;
  logic                b_rd_en;
  logic [B_IDX_W-1:0]  b_rd_addr;
  logic [DATA_W-1:0]   b_rd_data = '0;
  logic                b_valid;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_data;
  logic                b_clear;
  logic                b_busy;
  logic [DATA_W-1:0]   b_buf0 = '0;

  quant_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WORDS(N_WORDS),
                  .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .quant_done_flag(flag),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_clear(wb_clear), .wb_busy(wb_busy)
  );

  quant_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WORDS(1),
                  .BASE_ADDR('h10)) dut_one (
    .clk(clk), .rst_n(rst_n), .quant_done_flag(b_flag),
    .buf_rd_en(b_rd_en), .buf_rd_addr(b_rd_addr), .buf_rd_data(b_rd_data),
    .mem_wr_valid(b_valid), .mem_wr_ready(1'b1),
    .mem_wr_addr(b_addr), .mem_wr_data(b_data),
    .wb_clear(b_clear), .wb_busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Result buffers with one-cycle read latency
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= buf_mem[buf_rd_addr];
    if (b_rd_en) b_rd_data <= b_buf0;
  end

  // Sticky quant-done flag as the parent would hold it; clear wins.
  always @(posedge clk) begin
    if (wb_clear) flag <= 1'b0;
    else if (flag_set) flag <= 1'b1;
    else if (flag_drop) flag <= 1'b0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and reference timing: a block starts the cycle the idle
  // sequencer sees the flag; word k is read one cycle after the previous
  // acceptance, offered two cycles after its read, and the clear comes the
  // cycle after the last acceptance.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic model_idle = 1'b1;
  int   words_done = 0;
  int   rd_cyc = 0;
  int   trig_cyc = 0;
  int   clr_cyc = 0;
  int   blocks_done = 0;

  always @(negedge clk) begin
    logic exp_rd, exp_valid, exp_clear;
    logic [ADDR_W+DATA_W-1:0] f;
    if (!rst_n) begin
      exp_q.delete();
      model_idle = 1'b1;
      words_done = 0;
    end else if (model_idle) begin
      checkOutput("idle_busy", 32'(wb_busy), 0);
      checkOutput("idle_rd_en", 32'(buf_rd_en), 0);
      checkOutput("idle_valid", 32'(mem_wr_valid), 0);
      checkOutput("idle_clear", 32'(wb_clear), 0);
      if (flag) begin
        model_idle = 1'b0;
        words_done = 0;
        trig_cyc   = cyc;
        rd_cyc     = cyc + 1;
        for (int k = 0; k < N_WORDS; k++)
          exp_q.push_back({ADDR_W'((BASE_ADDR + k) % (1 << ADDR_W)), buf_mem[k]});
      end
    end else begin
      exp_rd    = (words_done < N_WORDS) && (cyc == rd_cyc);
      exp_valid = (words_done < N_WORDS) && (cyc >= rd_cyc + 2);
      exp_clear = (words_done == N_WORDS);
      checkOutput("busy", 32'(wb_busy), 1);
      checkOutput("rd_en", 32'(buf_rd_en), 32'(exp_rd));
      if (exp_rd) checkOutput("rd_addr", 32'(buf_rd_addr), 32'(words_done));
      checkOutput("wr_valid", 32'(mem_wr_valid), 32'(exp_valid));
      checkOutput("clear", 32'(wb_clear), 32'(exp_clear));
      if (mem_wr_valid && exp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_empty", 1, 0);
        end else begin
          f = exp_q[0];
          checkOutput("wr_addr", 32'(mem_wr_addr), 32'(f[ADDR_W+DATA_W-1:DATA_W]));
          checkOutput("wr_data", 32'(mem_wr_data), 32'(f[DATA_W-1:0]));
          if (mem_wr_ready) begin
            void'(exp_q.pop_front());
            words_done++;
            rd_cyc = cyc + 1;
          end
        end
      end
      if (exp_clear) begin
        model_idle = 1'b1;
        clr_cyc = cyc;
        blocks_done++;
      end
    end
  end

  // Ready driver: optional stall window on a chosen word, optional random.
  logic rand_ready = 1'b0;
  int   stall_word = -1;
  int   stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && mem_wr_valid && words_done == stall_word) begin
      mem_wr_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      mem_wr_ready = ($urandom_range(0, 3) != 0);
    end else begin
      mem_wr_ready = 1'b1;
    end
  end

  // Pulse the parent's "done" event for one cycle.
  task automatic applyStimulus();
    @(posedge clk); #2;
    flag_set = 1'b1;
    @(posedge clk); #2;
    flag_set = 1'b0;
  endtask

  task automatic waitBlock(input int target, input string name);
    int n = 0;
    while (blocks_done < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, 32'(blocks_done >= target), 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_en"}, 32'(buf_rd_en), 0);
    checkOutput({tag, "_rd_addr"}, 32'(buf_rd_addr), 0);
    checkOutput({tag, "_valid"}, 32'(mem_wr_valid), 0);
    checkOutput({tag, "_addr"}, 32'(mem_wr_addr), 0);
    checkOutput({tag, "_data"}, 32'(mem_wr_data), 0);
    checkOutput({tag, "_clear"}, 32'(wb_clear), 0);
    checkOutput({tag, "_busy"}, 32'(wb_busy), 0);
  endtask

  initial begin
    int target;
    int n;
    int dly;

    // Reset, then a long idle stretch with the flag low
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Directed block, ready always high: clear 13 cycles after trigger
    buf_mem[0] = 8'h11; buf_mem[1] = 8'h22; buf_mem[2] = 8'h33; buf_mem[3] = 8'h44;
    target = blocks_done + 1;
    applyStimulus();
    waitBlock(target, "blk_plain_done");
    checkOutput("plain_clear_cycle", 32'(clr_cyc - trig_cyc), 13);
    repeat (10) @(posedge clk);

    // Five stall cycles on word 2 push the clear out to 18
    stall_word = 2;
    stall_left = 5;
    target = blocks_done + 1;
    applyStimulus();
    waitBlock(target, "blk_stall_done");
    checkOutput("stall_clear_cycle", 32'(clr_cyc - trig_cyc), 18);
    checkOutput("stall_consumed", 32'(stall_left), 0);
    stall_word = -1;
    repeat (5) @(posedge clk);

    // Reset during the write of word 1; flag stays high and a fresh block runs
    for (int k = 0; k < N_WORDS; k++) buf_mem[k] = 8'($urandom);
    applyStimulus();
    n = 0;
    while (!(words_done == 1 && mem_wr_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reach_word1", 32'(n < 100), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    target = blocks_done + 1;
    waitBlock(target, "blk_after_reset");
    checkOutput("restart_clear_cycle", 32'(clr_cyc - trig_cyc), 13);
    repeat (5) @(posedge clk);

    // Random blocks with random ready and the flag dropping mid-sequence
    rand_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < N_WORDS; k++) buf_mem[k] = 8'($urandom);
      target = blocks_done + 1;
      applyStimulus();
      dly = $urandom_range(1, 8);
      repeat (dly) @(posedge clk);
      #2;
      flag_drop = 1'b1;
      @(posedge clk); #2;
      flag_drop = 1'b0;
      waitBlock(target, "blk_random_done");
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    rand_ready = 1'b0;
    repeat (5) @(posedge clk);

    // Single-word instance: write at t+3, clear at t+4, flag toggling ignored
    b_buf0 = 8'($urandom);
    @(posedge clk); #1;
    b_flag = 1'b1;
    @(negedge clk);
    checkOutput("one_t0_busy", 32'(b_busy), 0);
    @(negedge clk);
    checkOutput("one_t1_rd_en", 32'(b_rd_en), 1);
    checkOutput("one_t1_rd_addr", 32'(b_rd_addr), 0);
    checkOutput("one_t1_busy", 32'(b_busy), 1);
    b_flag = 1'b0;
    @(negedge clk);
    checkOutput("one_t2_rd_en", 32'(b_rd_en), 0);
    checkOutput("one_t2_valid", 32'(b_valid), 0);
    checkOutput("one_t2_busy", 32'(b_busy), 1);
    b_flag = 1'b1;
    @(negedge clk);
    checkOutput("one_t3_valid", 32'(b_valid), 1);
    checkOutput("one_t3_addr", 32'(b_addr), 'h10);
    checkOutput("one_t3_data", 32'(b_data), 32'(b_buf0));
    checkOutput("one_t3_clear", 32'(b_clear), 0);
    @(negedge clk);
    checkOutput("one_t4_clear", 32'(b_clear), 1);
    checkOutput("one_t4_valid", 32'(b_valid), 0);
    b_flag = 1'b0;
    @(negedge clk);
    checkOutput("one_t5_busy", 32'(b_busy), 0);
    checkOutput("one_t5_clear", 32'(b_clear), 0);
    repeat (3) @(negedge clk);
    checkOutput("one_no_retrigger", 32'(b_rd_en | b_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
